// File: rtl/pwm_timer_mc.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_timer_mc
//  Purpose  : Multi-channel PWM timer. One prescaled up-counter timebase is
//             shared by N_CH comparators. Period and duty values are double
//             buffered and swap in at a counter wrap. Supports one-shot and
//             continuous modes.
//             Optional capture unit, built when PWM_TIMER_MC_CAPTURE_EN is
//             defined: it latches the counter on a rising edge of capture_i.
//  Revision : 1.0  initial release
// ============================================================================
module pwm_timer_mc #(
    parameter int CNT_W = 16,
    parameter int N_CH  = 4,
    parameter int PS_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  oneshot_i,
    input  logic [PS_W-1:0]       prescale_i,
    input  logic [CNT_W-1:0]      period_i,
    input  logic [N_CH*CNT_W-1:0] duty_i,
    input  logic                  update_i,
    input  logic                  capture_i,
    input  logic                  clear_i,
    output logic [N_CH-1:0]       pwm_o,
    output logic [CNT_W-1:0]      cnt_o,
    output logic                  running_o,
    output logic                  wrap_o,
    output logic [CNT_W-1:0]      cap_value_o,
    output logic                  cap_valid_o
);

    localparam logic [0:0]       c_st_idle = 1'b0;
    localparam logic [0:0]       c_st_run  = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PS_W-1:0]  c_ps_one  = PS_W'(1);

    logic [0:0]            r_state;
    logic [PS_W-1:0]       r_presc;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_period_sh;
    logic [N_CH*CNT_W-1:0] r_duty_sh;
    logic                  r_pending;
    logic [N_CH-1:0]       r_pwm;

    logic                  w_run;
    logic                  w_tick;
    logic                  w_at_top;
    logic                  w_start;
    logic                  w_stop;
    logic                  w_wrap;
    logic                  w_reload;
    logic                  w_run_next;
    logic [N_CH-1:0]       w_pwm_next;

    // Event decode. The >= compares keep the prescaler and the counter
    // bounded even if prescale_i is lowered while running.
    assign w_run      = (r_state == c_st_run);
    assign w_tick     = (r_presc >= prescale_i);
    assign w_at_top   = (r_cnt >= r_period_sh);
    assign w_start    = en_i && !w_run && start_i && !stop_i;
    assign w_stop     = en_i && w_run && stop_i;
    assign w_wrap     = !rst_i && en_i && w_run && !stop_i && w_tick && w_at_top;
    assign w_reload   = w_wrap && (r_pending || update_i);
    assign w_run_next = (w_run && !(w_stop || (w_wrap && oneshot_i))) || w_start;

    // Per-channel compare. The output is forced low on the edge that leaves
    // RUN so no stale high level leaks into IDLE.
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_ch
            assign w_pwm_next[k] = w_run && w_run_next &&
                                   (r_cnt < r_duty_sh[k*CNT_W +: CNT_W]);
        end
    endgenerate

    // FSM, prescaler, counter, shadow registers and pending-update flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_st_idle;
            r_presc     <= '0;
            r_cnt       <= '0;
            r_period_sh <= '0;
            r_duty_sh   <= '0;
            r_pending   <= 1'b0;
            r_pwm       <= '0;
        end else if (en_i) begin
            r_state <= w_run_next ? c_st_run : c_st_idle;
            r_pwm   <= w_pwm_next;
            if (w_start) begin
                r_presc     <= '0;
                r_cnt       <= '0;
                r_period_sh <= period_i;
                r_duty_sh   <= duty_i;
                r_pending   <= 1'b0;
            end else if (w_run && !stop_i) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_cnt   <= w_at_top ? '0 : (r_cnt + c_cnt_one);
                end else begin
                    r_presc <= r_presc + c_ps_one;
                end
                if (w_reload) begin
                    r_period_sh <= period_i;
                    r_duty_sh   <= duty_i;
                end
                if (w_wrap) begin
                    r_pending <= 1'b0;
                end else if (update_i) begin
                    r_pending <= 1'b1;
                end
            end else if (update_i) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign cnt_o     = r_cnt;
    assign running_o = w_run;
    assign wrap_o    = w_wrap;

`ifdef PWM_TIMER_MC_CAPTURE_EN
    logic             r_cap_prev;
    logic [CNT_W-1:0] r_cap_value;
    logic             r_cap_valid;

    // Capture on rising edge of capture_i; clear_i overrides and works even
    // while en_i is low
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cap_prev  <= 1'b0;
            r_cap_value <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            if (clear_i) begin
                r_cap_value <= '0;
                r_cap_valid <= 1'b0;
            end else if (en_i && capture_i && !r_cap_prev) begin
                r_cap_value <= r_cnt;
                r_cap_valid <= 1'b1;
            end
            if (en_i) begin
                r_cap_prev <= capture_i;
            end
        end
    end

    assign cap_value_o = r_cap_value;
    assign cap_valid_o = r_cap_valid;
`else
    logic w_unused_cap;
    assign w_unused_cap = capture_i ^ clear_i;
    assign cap_value_o  = '0;
    assign cap_valid_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_timer_mc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_pwm_timer_mc
//  Purpose  : Self-checking bench for pwm_timer_mc. Table of timer setups
//             checked against a closed-form waveform model through an
//             expected-value queue, plus hand sequences for shadow update,
//             capture, enable freeze, reset and stop.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pwm_timer_mc;
    localparam int CNT_W = 16;
    localparam int N_CH  = 4;
    localparam int PS_W  = 8;

    logic                  clk = 1'b0;
    logic                  rst_i, en_i, start_i, stop_i, oneshot_i;
    logic [PS_W-1:0]       prescale_i;
    logic [CNT_W-1:0]      period_i;
    logic [N_CH*CNT_W-1:0] duty_i;
    logic                  update_i, capture_i, clear_i;
    logic [N_CH-1:0]       pwm_o;
    logic [CNT_W-1:0]      cnt_o;
    logic                  running_o, wrap_o;
    logic [CNT_W-1:0]      cap_value_o;
    logic                  cap_valid_o;

    pwm_timer_mc #(.CNT_W(CNT_W), .N_CH(N_CH), .PS_W(PS_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
        .stop_i(stop_i), .oneshot_i(oneshot_i), .prescale_i(prescale_i),
        .period_i(period_i), .duty_i(duty_i), .update_i(update_i),
        .capture_i(capture_i), .clear_i(clear_i), .pwm_o(pwm_o),
        .cnt_o(cnt_o), .running_o(running_o), .wrap_o(wrap_o),
        .cap_value_o(cap_value_o), .cap_valid_o(cap_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                    ps;
        int                    per;
        logic [N_CH*CNT_W-1:0] duty;
        logic                  oneshot;
        int                    ncyc;
    } vec_t;

    typedef struct packed {
        logic [N_CH-1:0]  pwm;
        logic [CNT_W-1:0] cnt;
        logic             wrap;
        logic             run;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counter value n cycles after the start edge, from the tick arithmetic
    function automatic int cnt_at(input int n, input int ps, input int per);
        return (n / (ps + 1)) % (per + 1);
    endfunction

    function automatic exp_t model(input vec_t v, input int n);
        exp_t e;
        int   t;
        t = (v.ps + 1) * (v.per + 1);
        e = '0;
        if (v.oneshot && n >= t) return e;
        e.run  = 1'b1;
        e.cnt  = CNT_W'(cnt_at(n, v.ps, v.per));
        e.wrap = ((n % t) == t - 1);
        for (int k = 0; k < N_CH; k++) begin
            e.pwm[k] = (n >= 1) &&
                       (cnt_at(n - 1, v.ps, v.per) < int'(v.duty[k*CNT_W +: CNT_W]));
        end
        return e;
    endfunction

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        update_i = 1'b0; capture_i = 1'b0; clear_i = 1'b0;
        step();
        rst_i = 1'b0;
    endtask

    task automatic start_run(input vec_t v);
        prescale_i = PS_W'(v.ps);
        period_i   = CNT_W'(v.per);
        duty_i     = v.duty;
        oneshot_i  = v.oneshot;
        start_i    = 1'b1;
        step();
        start_i    = 1'b0;
    endtask

    vec_t vecs[4];
    vec_t hv;
    exp_t e;
    int   exp_cap;

    initial begin
        // duty fields are listed ch3, ch2, ch1, ch0
        vecs[0] = '{ps: 0, per: 9, duty: {16'd9, 16'd10, 16'd0, 16'd3}, oneshot: 1'b0, ncyc: 30};
        vecs[1] = '{ps: 3, per: 4, duty: {16'd1, 16'd0, 16'd5, 16'd2}, oneshot: 1'b1, ncyc: 26};
        vecs[2] = '{ps: 1, per: 6, duty: {16'd6, 16'd1, 16'd3, 16'd7}, oneshot: 1'b0, ncyc: 30};
        vecs[3] = '{ps: 0, per: 0, duty: {16'd0, 16'd2, 16'd0, 16'd1}, oneshot: 1'b0, ncyc: 10};

        prescale_i = '0; period_i = '0; duty_i = '0; oneshot_i = 1'b0;
        rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; stop_i = 1'b0;
        update_i = 1'b0; capture_i = 1'b0; clear_i = 1'b0;
        step();
        step();
        check("reset pwm", int'(pwm_o), 0);
        check("reset cnt", int'(cnt_o), 0);
        check("reset running", int'(running_o), 0);
        check("reset wrap", int'(wrap_o), 0);
        check("reset cap_value", int'(cap_value_o), 0);
        check("reset cap_valid", int'(cap_valid_o), 0);
        rst_i = 1'b0;

        // Table-driven runs against the closed-form waveform model
        for (int i = 0; i < 4; i++) begin
            do_reset();
            start_run(vecs[i]);
            for (int n = 0; n < vecs[i].ncyc; n++) begin
                sb.push_back(model(vecs[i], n));
                e = sb.pop_front();
                check($sformatf("v%0d n%0d pwm", i, n), int'(pwm_o), int'(e.pwm));
                check($sformatf("v%0d n%0d cnt", i, n), int'(cnt_o), int'(e.cnt));
                check($sformatf("v%0d n%0d wrap", i, n), int'(wrap_o), int'(e.wrap));
                check($sformatf("v%0d n%0d running", i, n), int'(running_o), int'(e.run));
                step();
            end
        end

        // Shadow update: duty ch0 3 -> 7 applies only from the next period;
        // a later duty change without update_i must not apply
        hv = '{ps: 0, per: 9, duty: {16'd0, 16'd0, 16'd0, 16'd3}, oneshot: 1'b0, ncyc: 0};
        do_reset();
        start_run(hv);
        for (int n = 0; n < 32; n++) begin
            check($sformatf("upd n%0d cnt", n), int'(cnt_o), n % 10);
            check($sformatf("upd n%0d pwm0", n), int'(pwm_o[0]),
                  int'((n >= 1) && (((n - 1) % 10) < (((n - 1) >= 10) ? 7 : 3))));
            if (n == 2)  duty_i[CNT_W-1:0] = 16'd7;
            if (n == 4)  update_i = 1'b1;
            if (n == 5)  update_i = 1'b0;
            if (n == 12) duty_i[CNT_W-1:0] = 16'd1;
            step();
        end

        // Capture at cnt 5, held level does not re-trigger, clear beats capture
`ifdef PWM_TIMER_MC_CAPTURE_EN
        exp_cap = 1;
`else
        exp_cap = 0;
`endif
        do_reset();
        start_run(hv);
        for (int n = 0; n < 13; n++) begin
            if (n == 3) begin
                check("cap idle valid", int'(cap_valid_o), 0);
            end
            if (n == 6 || n == 8) begin
                check($sformatf("cap n%0d value", n), int'(cap_value_o), 5 * exp_cap);
                check($sformatf("cap n%0d valid", n), int'(cap_valid_o), exp_cap);
            end
            if (n == 11 || n == 12) begin
                check($sformatf("clr n%0d value", n), int'(cap_value_o), 0);
                check($sformatf("clr n%0d valid", n), int'(cap_valid_o), 0);
            end
            if (n == 5)  capture_i = 1'b1;
            if (n == 9)  capture_i = 1'b0;
            if (n == 10) begin capture_i = 1'b1; clear_i = 1'b1; end
            if (n == 11) clear_i = 1'b0;
            step();
        end
        capture_i = 1'b0;

        // Enable freeze (stop ignored), reset with en_i low, restart, stop,
        // and start+stop together
        do_reset();
        start_run(hv);
        step();
        step();                                   // n = 2
        check("frz n2 cnt", int'(cnt_o), 2);
        check("frz n2 pwm0", int'(pwm_o[0]), 1);
        en_i = 1'b0;
        step();                                   // n = 3
        stop_i = 1'b1;
        step();                                   // n = 4
        stop_i = 1'b0;
        check("frz n4 running", int'(running_o), 1);
        check("frz n4 cnt", int'(cnt_o), 2);
        step();                                   // n = 5
        check("frz n5 cnt", int'(cnt_o), 2);
        check("frz n5 pwm0", int'(pwm_o[0]), 1);
        en_i = 1'b1;
        step();                                   // n = 6
        check("frz n6 cnt", int'(cnt_o), 3);
        check("frz n6 pwm0", int'(pwm_o[0]), 1);
        step();                                   // n = 7
        check("frz n7 cnt", int'(cnt_o), 4);
        check("frz n7 pwm0", int'(pwm_o[0]), 0);
        en_i = 1'b0;
        rst_i = 1'b1;
        step();                                   // n = 8
        check("rst n8 pwm", int'(pwm_o), 0);
        check("rst n8 cnt", int'(cnt_o), 0);
        check("rst n8 running", int'(running_o), 0);
        check("rst n8 wrap", int'(wrap_o), 0);
        rst_i = 1'b0;
        en_i = 1'b1;
        start_i = 1'b1;
        step();                                   // n = 9
        start_i = 1'b0;
        check("rst n9 running", int'(running_o), 1);
        check("rst n9 cnt", int'(cnt_o), 0);
        step();                                   // n = 10
        check("rst n10 cnt", int'(cnt_o), 1);
        check("rst n10 pwm0", int'(pwm_o[0]), 1);
        step();                                   // n = 11
        stop_i = 1'b1;
        step();                                   // n = 12
        stop_i = 1'b0;
        check("stop n12 running", int'(running_o), 0);
        check("stop n12 cnt", int'(cnt_o), 2);
        check("stop n12 pwm", int'(pwm_o), 0);
        check("stop n12 wrap", int'(wrap_o), 0);
        step();                                   // n = 13
        check("stop n13 cnt", int'(cnt_o), 2);
        start_i = 1'b1;
        stop_i = 1'b1;
        step();                                   // n = 14
        start_i = 1'b0;
        stop_i = 1'b0;
        check("both n14 running", int'(running_o), 0);
        check("both n14 cnt", int'(cnt_o), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_timer_mc.md
PWM_TIMER_MC -- requirements
Module: pwm_timer_mc

Interface
REQ-001 Parameter CNT_W, default 16: counter, period and duty width.
REQ-002 Parameter N_CH, default 4: number of PWM channels sharing one timebase.
REQ-003 Parameter PS_W, default 8: prescaler width.
REQ-004 clk_i  in  1  the only clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 en_i  in  1  global enable; 0 freezes all state except reset and clear_i.
REQ-007 start_i  in  1  pulse, starts timer (software trigger).
REQ-008 stop_i  in  1  pulse, stops timer.
REQ-009 oneshot_i  in  1  1 = stop after one period, 0 = continuous.
REQ-010 prescale_i  in  PS_W  timebase divisor minus 1.
REQ-011 period_i  in  CNT_W  terminal count; period is period_i+1 ticks.
REQ-012 duty_i  in  N_CH*CNT_W  per-channel high time; channel k in bits [k*CNT_W +: CNT_W].
REQ-013 update_i  in  1  pulse, requests shadow reload at next wrap.
REQ-014 capture_i  in  1  capture event, rising-edge detected.
REQ-015 clear_i  in  1  clears capture result and valid flag.
REQ-016 pwm_o  out  N_CH  registered PWM outputs.
REQ-017 cnt_o  out  CNT_W  current counter value.
REQ-018 running_o  out  1  1 while in RUN.
REQ-019 wrap_o  out  1  one-cycle pulse on counter wrap.
REQ-020 cap_value_o  out  CNT_W  captured counter value.
REQ-021 cap_valid_o  out  1  capture result held.

Function
REQ-022 FSM states IDLE, RUN; IDLE->RUN on start_i, RUN->IDLE on stop_i, or on wrap when oneshot_i=1; stop_i wins over simultaneous start_i.
REQ-023 On IDLE->RUN: prescaler and counter = 0, period_i/duty_i loaded into shadow registers, pending update cleared.
REQ-024 Prescaler counts 0..prescale_i in RUN; tick when it equals prescale_i, then returns to 0; prescale_i=0 gives tick every cycle.
REQ-025 Counter increments on tick; at tick with cnt_o == period_sh it wraps to 0 and wrap_o pulses for that cycle.
REQ-026 update_i sets a pending flag; at the next wrap shadows reload from inputs and flag clears; update_i coincident with wrap applies at that wrap.
REQ-027 pwm_o[k] = running && cnt_o < duty_sh[k], registered: 1-cycle latency after cnt_o.
REQ-028 duty_sh[k]=0 -> constant low; duty_sh[k] > period_sh -> constant high in RUN.
REQ-029 In IDLE pwm_o = 0, cnt_o holds last value until next start.
REQ-030 All arithmetic unsigned, width CNT_W / PS_W, no overflow past period_sh.
REQ-031 en_i=0 holds FSM, prescaler, counter, pending flag and pwm_o; start/stop/update ignored.

Reset
REQ-032 rst_i=1 at clock edge: state IDLE, pwm_o=0, cnt_o=0, running_o=0, wrap_o=0, cap_value_o=0, cap_valid_o=0, shadows=0, pending=0, prescaler=0.
REQ-033 Reset mid-RUN takes effect at the same edge, overrides every other input.

Configuration
REQ-034 Macro PWM_TIMER_MC_CAPTURE_EN defined: capture unit present per REQ-035..037.
REQ-035 Rising edge of capture_i (registered previous sample) latches cnt_o into cap_value_o and sets cap_valid_o, regardless of running_o.
REQ-036 clear_i zeroes cap_value_o and cap_valid_o; clear_i wins over simultaneous capture.
REQ-037 Macro not defined: capture_i, clear_i ignored; cap_value_o and cap_valid_o tied 0; no capture flops.

Verification
REQ-038 CNT_W=16, prescale_i=0, period_i=9, duty_i ch0=3, start_i -> pwm_o[0] high 3 of every 10 cycles, wrap_o every 10 cycles.
REQ-039 duty ch1=0, ch2=10, period_i=9 -> pwm_o[1] always 0, pwm_o[2] always 1 while running.
REQ-040 prescale_i=3, oneshot_i=1, period_i=4 -> one period of 20 cycles, running_o falls at wrap, pwm_o=0 after.
REQ-041 Change duty ch0 3->7 mid-period with update_i -> old duty until wrap, new duty from first cycle of next period.
REQ-042 capture_i rising at cnt_o=5 -> cap_value_o=5, cap_valid_o=1; clear_i with capture same cycle -> both 0.
REQ-043 rst_i asserted mid-RUN with en_i=0 -> all outputs 0 next edge; start_i then restarts from cnt_o=0.
